wdt_core: RTL and testbench
===========================

# wdt_core

Watchdog timer core for the WDT peripheral. It consumes the three configuration streams (enable, kick/live, timeout count) that the AXI slave wrapper delivers through its per-register async FIFOs, one valid-qualified word per pop. It runs a timeout counter and raises a level interrupt toward the CPU when the count expires without a kick. The block is single-clock: it sits entirely in the timer clock domain, and the integration connects that domain's clock and reset to clk and rst.

## Interface
- CNT_W, 32: width of timeout threshold and counter.
- RESET_TIMEOUT, {CNT_W{1'b1}}: threshold value after reset.
- EVT_W, 8: width of saturating timeout-event counter.

- clk  in  1  timer-domain clock; all state on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- WDEN  in  1  enable value (bit 0 of FIFO word); sampled only when WDEN_RVALID=1.
- WDEN_RVALID  in  1  one-cycle-per-word valid (FIFO not empty).
- WDLIVE  in  1  kick value; sampled only when WDLIVE_RVALID=1.
- WDLIVE_RVALID  in  1  valid for WDLIVE.
- WTOCNT  in  CNT_W  timeout threshold; sampled only when WTOCNT_RVALID=1.
- WTOCNT_RVALID  in  1  valid for WTOCNT.
- WTO_interrupt  out  1  registered timeout interrupt, level.
- wto_events  out  EVT_W  saturating count of COUNT->TIMEOUT transitions.
- wdt_active  out  1  registered; 1 in COUNT or TIMEOUT.

## Operation
- Registers: enable flag en, threshold thr, counter cnt, state.
- States: IDLE (disabled), COUNT, TIMEOUT.
- thr loads WTOCNT on every WTOCNT_RVALID, in any state; the new value takes effect for the compare on the next cycle.
- IDLE: cnt held 0. WDEN_RVALID&WDEN -> COUNT, cnt<=0.
- COUNT: if cnt >= thr -> TIMEOUT; else cnt<=cnt+1. A kick (WDLIVE_RVALID&WDLIVE) sets cnt<=0 and stays in COUNT.
- TIMEOUT: cnt frozen, WTO_interrupt=1. Kick -> COUNT, cnt<=0, interrupt clears.
- Disable (WDEN_RVALID&~WDEN) in any state -> IDLE, cnt<=0, interrupt clears.
- Priority in a single cycle: disable > kick > timeout compare. Enable while already in COUNT or TIMEOUT is ignored and does not restart the count. A kick with WDLIVE=0 is ignored.
- Words arriving with valid low are ignored regardless of data value.
- wto_events increments on each COUNT->TIMEOUT transition and saturates at all-ones. It is never cleared except by rst.
- cnt never wraps: it is compared with >=, so a threshold lowered below cnt forces a timeout on the next compare.

## Timing
- Reset values: state=IDLE, cnt=0, thr=RESET_TIMEOUT, WTO_interrupt=0, wto_events=0, wdt_active=0.
- rst asserted mid-operation returns all of the above immediately; an interrupt drops asynchronously.
- Enable sampled at edge k -> wdt_active=1 after edge k. With thr=N and no kicks, WTO_interrupt rises after edge k+N+1.
- thr=0: interrupt rises after edge k+1.
- Kick sampled at edge j -> interrupt low after edge j. The next timeout occurs after edge j+N+1.
- All outputs are registered, with no combinational input-to-output path.
- All valids may be asserted in the same cycle. Each input is processed in that cycle under the stated priority, and the thr load applies alongside.

## Structure
- Shared package wdt_pkg: state enum wdt_state_t {IDLE, COUNT, TIMEOUT}, and the register address constants 32'h1001_0100 (WDEN), 32'h1001_0200 (WDLIVE), 32'h1001_0300 (WTOCNT) shared with the AXI wrapper.
- No sub-module needed. The saturating event counter is inline logic.

## Test plan
- Reset, thr=RESET_TIMEOUT; enable, run 100 cycles -> interrupt stays 0; wdt_active=1 after the enable edge.
- WTOCNT=5, then enable at edge k -> interrupt high after edge k+6; wto_events=1.
- WTOCNT=10, enable, kick every 8 cycles for 50 cycles -> interrupt never asserts. Stop kicking -> interrupt rises 11 edges after the last kick.
- In TIMEOUT, assert WDLIVE_RVALID and WDEN_RVALID(WDEN=0) in the same cycle -> state IDLE, interrupt 0, cnt 0. A later enable needs the full thr+1 cycles to time out.
- WTOCNT=1000, enable, wait 50 cycles, write WTOCNT=20 -> interrupt high within 2 cycles. WDLIVE=0 with valid, and WDEN=1 with valid while counting -> no effect on cnt.
- EVT_W=2: force 5 timeouts (kick after each) -> wto_events saturates at 3. Assert rst mid-count -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timer: FSM state encoding and the
// register map the AXI wrapper decodes.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        TIMEOUT = 2'd2
    } wdt_state_t;

    localparam logic [31:0] WDEN_ADDR   = 32'h1001_0100;
    localparam logic [31:0] WDLIVE_ADDR = 32'h1001_0200;
    localparam logic [31:0] WTOCNT_ADDR = 32'h1001_0300;

endpackage

// File: rtl/wdt_core.sv
// Watchdog timer core: consumes enable/kick/threshold words from the wrapper FIFOs,
// counts toward the threshold and raises a level interrupt on expiry.
module wdt_core
    import wdt_pkg::*;
#(
    parameter int                CNT_W         = 32,
    parameter logic [CNT_W-1:0]  RESET_TIMEOUT = {CNT_W{1'b1}},
    parameter int                EVT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WDEN,
    input  logic              WDEN_RVALID,
    input  logic              WDLIVE,
    input  logic              WDLIVE_RVALID,
    input  logic [CNT_W-1:0]  WTOCNT,
    input  logic              WTOCNT_RVALID,
    output logic              WTO_interrupt,
    output logic [EVT_W-1:0]  wto_events,
    output logic              wdt_active,
    output wdt_state_t        wdt_state
);

    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    wdt_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;
    logic             dis_req;
    logic             en_req;
    logic             kick;

    // Each FIFO word counts only when its valid is high.
    assign dis_req = WDEN_RVALID & ~WDEN;
    assign en_req  = WDEN_RVALID & WDEN;
    assign kick    = WDLIVE_RVALID & WDLIVE;

    assign wdt_state = state;

    // Priority: disable > kick > threshold compare; thr loads alongside whatever happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            thr           <= RESET_TIMEOUT;
            WTO_interrupt <= 1'b0;
            wto_events    <= '0;
            wdt_active    <= 1'b0;
        end else begin
            if (WTOCNT_RVALID) begin
                thr <= WTOCNT;
            end
            if (dis_req) begin
                state         <= IDLE;
                cnt           <= '0;
                WTO_interrupt <= 1'b0;
                wdt_active    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (en_req) begin
                            state      <= COUNT;
                            wdt_active <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (kick) begin
                            cnt <= '0;
                        end else if (cnt >= thr) begin
                            state         <= TIMEOUT;
                            WTO_interrupt <= 1'b1;
                            if (wto_events != EVT_MAX) begin
                                wto_events <= wto_events + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    TIMEOUT: begin
                        // Counter stays frozen here until a kick or a disable.
                        if (kick) begin
                            state         <= COUNT;
                            cnt           <= '0;
                            WTO_interrupt <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        cnt           <= '0;
                        WTO_interrupt <= 1'b0;
                        wdt_active    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wdt_core.sv
// Bench for wdt_core: directed latency checks plus random traffic, with an
// edge-arithmetic reference model feeding a per-cycle scoreboard.
module tb_wdt_core;
    import wdt_pkg::*;

    localparam int CNT_W = 32;
    localparam int EVT_W = 2;
    localparam int EXP_W = 1 + 1 + EVT_W + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             WDEN = 1'b0;
    logic             WDEN_RVALID = 1'b0;
    logic             WDLIVE = 1'b0;
    logic             WDLIVE_RVALID = 1'b0;
    logic [CNT_W-1:0] WTOCNT = '0;
    logic             WTOCNT_RVALID = 1'b0;
    logic             WTO_interrupt;
    logic [EVT_W-1:0] wto_events;
    logic             wdt_active;
    wdt_state_t       wdt_state;

    always #5 clk = ~clk;

    wdt_core #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
        .clk(clk), .rst(rst),
        .WDEN(WDEN), .WDEN_RVALID(WDEN_RVALID),
        .WDLIVE(WDLIVE), .WDLIVE_RVALID(WDLIVE_RVALID),
        .WTOCNT(WTOCNT), .WTOCNT_RVALID(WTOCNT_RVALID),
        .WTO_interrupt(WTO_interrupt), .wto_events(wto_events),
        .wdt_active(wdt_active), .wdt_state(wdt_state)
    );

    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the timer fires at the first edge e with e - restart - 1 >= thr.
    bit     m_en;
    bit     m_fired;
    longint m_restart;
    longint m_thr;
    longint m_edge = 0;
    int     m_events;

    task automatic model_reset();
        m_en      = 1'b0;
        m_fired   = 1'b0;
        m_restart = 0;
        m_thr     = (longint'(1) << CNT_W) - 1;
        m_events  = 0;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [1:0] st;
        m_edge++;
        if (WDEN_RVALID && !WDEN) begin
            m_en    = 1'b0;
            m_fired = 1'b0;
        end else if (!m_en) begin
            if (WDEN_RVALID && WDEN) begin
                m_en      = 1'b1;
                m_fired   = 1'b0;
                m_restart = m_edge;
            end
        end else if (WDLIVE_RVALID && WDLIVE) begin
            m_fired   = 1'b0;
            m_restart = m_edge;
        end else if (!m_fired && (m_edge - m_restart - 1) >= m_thr) begin
            m_fired = 1'b1;
            if (m_events < (1 << EVT_W) - 1) m_events++;
        end
        if (WTOCNT_RVALID) m_thr = longint'(WTOCNT);
        st = !m_en ? 2'd0 : (m_fired ? 2'd2 : 2'd1);
        exp_q.push_back({m_fired, m_en, EVT_W'(m_events), st});
        @(posedge clk);
        #2;
        WDEN_RVALID   = 1'b0;
        WDLIVE_RVALID = 1'b0;
        WTOCNT_RVALID = 1'b0;
    endtask

    task automatic cycle(input logic ev, input logic e, input logic lv, input logic l,
                         input logic tv, input logic [CNT_W-1:0] t);
        WDEN_RVALID = ev; WDEN = e;
        WDLIVE_RVALID = lv; WDLIVE = l;
        WTOCNT_RVALID = tv; WTOCNT = t;
        tick();
    endtask

    task automatic wait_irq(input int max, output longint at);
        at = -1000;
        for (int i = 0; i < max; i++) begin
            cycle(0, 0, 0, 0, 0, '0);
            if (WTO_interrupt === 1'b1) begin
                at = m_edge;
                break;
            end
        end
    endtask

    logic [EXP_W-1:0] mon_exp;
    logic [EXP_W-1:0] mon_got;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {WTO_interrupt, wdt_active, wto_events, logic'(wdt_state[1]), logic'(wdt_state[0])};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_err++;
                $display("FAIL scoreboard irq/active/events/state: got %b expected %b (t=%0t)",
                         mon_got, mon_exp, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    initial begin
        longint k;
        longint j;
        longint at;
        bit     seen;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_irq", WTO_interrupt, 0);
        check("reset_events", wto_events, 0);
        check("reset_active", wdt_active, 0);
        check("reset_state", wdt_state, IDLE);
        rst = 1'b0;

        // Default threshold: long run without expiry.
        cycle(1, 1, 0, 0, 0, '0);
        check("active_after_enable", wdt_active, 1);
        repeat (100) cycle(0, 0, 0, 0, 0, '0);
        check("irq_default_thr", WTO_interrupt, 0);

        // thr=5: interrupt after edge k+6.
        cycle(1, 0, 0, 0, 1, 32'd5);
        cycle(1, 1, 0, 0, 0, '0);
        k = m_edge;
        wait_irq(20, at);
        check("lat_thr5", at - k, 6);
        check("events_after_first", wto_events, 1);

        // thr=10 with kicks every 8 cycles.
        cycle(1, 0, 0, 0, 1, 32'd10);
        cycle(1, 1, 0, 0, 0, '0);
        seen = 1'b0;
        j = m_edge;
        for (int i = 1; i <= 50; i++) begin
            if (i % 8 == 0) begin
                cycle(0, 0, 1, 1, 0, '0);
                j = m_edge;
            end else begin
                cycle(0, 0, 0, 0, 0, '0);
            end
            if (WTO_interrupt === 1'b1) seen = 1'b1;
        end
        check("irq_while_kicked", seen, 0);
        wait_irq(30, at);
        check("lat_after_last_kick", at - j, 11);

        // Disable beats kick in the same cycle.
        cycle(1, 0, 1, 1, 0, '0);
        check("dis_kick_state", wdt_state, IDLE);
        check("dis_kick_irq", WTO_interrupt, 0);
        cycle(1, 1, 0, 0, 0, '0);
        k = m_edge;
        wait_irq(30, at);
        check("lat_reenable", at - k, 11);

        // Lowering thr below cnt forces an immediate timeout.
        cycle(1, 0, 0, 0, 1, 32'd1000);
        cycle(1, 1, 0, 0, 0, '0);
        repeat (49) cycle(0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 1, 32'd20);
        k = m_edge;
        wait_irq(2, at);
        check("lat_thr_lowered", at - k, 1);
        cycle(0, 0, 1, 1, 0, '0);
        j = m_edge;
        cycle(0, 0, 1, 0, 0, '0);
        cycle(1, 1, 0, 0, 0, '0);
        wait_irq(40, at);
        check("lat_ignored_words", at - j, 21);

        // Saturating event counter.
        cycle(0, 0, 0, 0, 1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 1, 0, '0);
            wait_irq(10, at);
        end
        check("events_saturated", wto_events, 3);

        // thr=0: interrupt after edge k+1.
        cycle(1, 0, 0, 0, 1, 32'd0);
        cycle(1, 1, 0, 0, 0, '0);
        k = m_edge;
        wait_irq(5, at);
        check("lat_thr0", at - k, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 4, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 5, CNT_W'($urandom_range(0, 12)));
        end

        // Reset while the interrupt is high.
        cycle(1, 0, 0, 0, 1, 32'd3);
        cycle(1, 1, 0, 0, 0, '0);
        wait_irq(10, at);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_irq", WTO_interrupt, 0);
        check("midrst_events", wto_events, 0);
        check("midrst_active", wdt_active, 0);
        check("midrst_state", wdt_state, IDLE);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        cycle(1, 1, 0, 0, 0, '0);
        repeat (20) cycle(0, 0, 0, 0, 0, '0);
        check("post_rst_no_irq", WTO_interrupt, 0);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
